// File: rtl/fft_pkg.sv
// +----------------------------------------------------------------------+
// | fft_pkg                                                              |
// | Shared FFT helpers: default width, clog2, Q1.(W-1) twiddle values.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fft_pkg;

    localparam int  c_default_width = 16;
    localparam real c_pi            = 3.14159265358979323846;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Component of W^k = cos(2*pi*k/n) - j*sin(2*pi*k/n), rounded half away from zero.
    function automatic int twiddle_comp(input int k, input int n, input int width,
                                        input bit imag);
        real scale;
        real ang;
        real v;
        scale = real'((1 << (width - 1)) - 1);
        ang   = 2.0 * c_pi * real'(k) / real'(n);
        v     = imag ? -$sin(ang) * scale : $cos(ang) * scale;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cplx_mul.sv
// +----------------------------------------------------------------------+
// | cplx_mul                                                             |
// | Registered complex multiply, full precision then >>> (WIDTH-1).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cplx_mul #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic signed [WIDTH-1:0] p_re,
    output logic signed [WIDTH-1:0] p_im
);

    localparam int c_pw = 2 * WIDTH + 1;

    logic signed [2*WIDTH-1:0] w_rr, w_ii, w_ri, w_ir;
    logic signed [c_pw-1:0]    w_full_re, w_full_im;

    assign w_rr = a_re * b_re;
    assign w_ii = a_im * b_im;
    assign w_ri = a_re * b_im;
    assign w_ir = a_im * b_re;

    assign w_full_re = c_pw'(w_rr) - c_pw'(w_ii);
    assign w_full_im = c_pw'(w_ri) + c_pw'(w_ir);

    // Bits [2W-2:W-1] are the arithmetic shift by W-1 truncated to W bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en) begin
            p_re <= w_full_re[2*WIDTH-2:WIDTH-1];
            p_im <= w_full_im[2*WIDTH-2:WIDTH-1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdf_twiddle_rom.sv
// +----------------------------------------------------------------------+
// | sdf_twiddle_rom                                                      |
// | D-entry combinational twiddle ROM, W^k for k = 0 .. N/2-1.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sdf_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    localparam int KW   = clog2(N) - 1
) (
    input  logic [KW-1:0]           k,
    output logic signed [WIDTH-1:0] tw_re,
    output logic signed [WIDTH-1:0] tw_im
);

    logic signed [WIDTH-1:0] w_tab_re [N/2];
    logic signed [WIDTH-1:0] w_tab_im [N/2];

    for (genvar i = 0; i < N/2; i++) begin : g_rom
        localparam int c_re = twiddle_comp(i, N, WIDTH, 1'b0);
        localparam int c_im = twiddle_comp(i, N, WIDTH, 1'b1);
        assign w_tab_re[i] = WIDTH'(c_re);
        assign w_tab_im[i] = WIDTH'(c_im);
    end

    assign tw_re = w_tab_re[k];
    assign tw_im = w_tab_im[k];

endmodule

`default_nettype wire

// File: rtl/sdf_dif_stage.sv
// +----------------------------------------------------------------------+
// | sdf_dif_stage                                                        |
// | Radix-2 SDF decimation-in-frequency stage; define SDF_SCALE_EN for   |
// | halved (non-overflowing) sum/difference.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sdf_dif_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int N     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic                    out_first,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im
);

    localparam int c_d  = N / 2;
    localparam int c_cw = clog2(N);
    localparam int c_kw = c_cw - 1;

    logic [c_cw-1:0]         r_cnt;
    logic                    r_primed;
    logic                    r_sel_sum;
    logic                    r_out_valid;
    logic                    r_out_first;
    logic signed [WIDTH-1:0] r_sum_re, r_sum_im;
    logic signed [WIDTH-1:0] r_dly_re [c_d];
    logic signed [WIDTH-1:0] r_dly_im [c_d];

    logic                    w_phase_b;
    logic [c_kw-1:0]         w_k;
    logic signed [WIDTH-1:0] w_head_re, w_head_im;
    logic signed [WIDTH-1:0] w_sum_re, w_sum_im, w_diff_re, w_diff_im;
    logic signed [WIDTH-1:0] w_tw_re, w_tw_im, w_prod_re, w_prod_im;

    assign w_phase_b = r_cnt[c_cw-1];
    assign w_k       = r_cnt[c_kw-1:0];
    assign w_head_re = r_dly_re[0];
    assign w_head_im = r_dly_im[0];

`ifdef SDF_SCALE_EN
    logic signed [WIDTH:0] w_sum_x_re, w_sum_x_im, w_diff_x_re, w_diff_x_im;

    assign w_sum_x_re  = (WIDTH+1)'(w_head_re) + (WIDTH+1)'(in_re);
    assign w_sum_x_im  = (WIDTH+1)'(w_head_im) + (WIDTH+1)'(in_im);
    assign w_diff_x_re = (WIDTH+1)'(w_head_re) - (WIDTH+1)'(in_re);
    assign w_diff_x_im = (WIDTH+1)'(w_head_im) - (WIDTH+1)'(in_im);
    assign w_sum_re    = w_sum_x_re[WIDTH:1];
    assign w_sum_im    = w_sum_x_im[WIDTH:1];
    assign w_diff_re   = w_diff_x_re[WIDTH:1];
    assign w_diff_im   = w_diff_x_im[WIDTH:1];
`else
    assign w_sum_re  = w_head_re + in_re;
    assign w_sum_im  = w_head_im + in_im;
    assign w_diff_re = w_head_re - in_re;
    assign w_diff_im = w_head_im - in_im;
`endif

    sdf_twiddle_rom #(.N(N), .WIDTH(WIDTH)) u_rom (
        .k     (w_k),
        .tw_re (w_tw_re),
        .tw_im (w_tw_im)
    );

    cplx_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid & ~w_phase_b),
        .a_re  (w_head_re),
        .a_im  (w_head_im),
        .b_re  (w_tw_re),
        .b_im  (w_tw_im),
        .p_re  (w_prod_re),
        .p_im  (w_prod_im)
    );

    // Delay contents are masked by r_primed, so they carry no reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < c_d - 1; i++) begin
                r_dly_re[i] <= r_dly_re[i+1];
                r_dly_im[i] <= r_dly_im[i+1];
            end
            r_dly_re[c_d-1] <= w_phase_b ? w_diff_re : in_re;
            r_dly_im[c_d-1] <= w_phase_b ? w_diff_im : in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_primed    <= 1'b0;
            r_sel_sum   <= 1'b0;
            r_sum_re    <= '0;
            r_sum_im    <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
        end else begin
            r_out_valid <= in_valid & (w_phase_b | r_primed);
            r_out_first <= in_valid & (r_cnt == c_cw'(c_d));
            if (in_valid) begin
                r_cnt     <= r_cnt + 1'b1;
                r_primed  <= r_primed | w_phase_b;
                r_sel_sum <= w_phase_b;
                if (w_phase_b) begin
                    r_sum_re <= w_sum_re;
                    r_sum_im <= w_sum_im;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_first = r_out_first;
    assign out_re    = r_sel_sum ? r_sum_re : w_prod_re;
    assign out_im    = r_sel_sum ? r_sum_im : w_prod_im;

endmodule

`default_nettype wire
